stc_frame_scheduler: RTL and testbench
======================================

Name: stc_frame_scheduler

Overview:
- Per-frame controller for the STC demod frame-alignment sample buffer and the trellis behind it.
- Pairs start-of-frame events with channel-estimate completion and issues one trellis-start pulse per frame.
- Counts decimated output samples and issues the end-of-frame last-sample reset.
- Watches for stalls, missed frames and buffer overflow, and reports sticky status to the register block.

Parameters:
- FRAME_OUTPUTS, 3200: output samples (buffer output strobes) per frame.
- FLUSH_CLKS, 8: enabled clocks held in FLUSH after a frame ends.
- TIMEOUT_CLKS, 1024: enabled clocks without an output strobe in RUN before a stall is declared.
- CNT_WIDTH, 16: width of the sample and timeout counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- clkEn  in  1  clock enable; all state advances only when high
- enable  in  1  scheduler enable; low forces IDLE and clears pending latches
- clearErrors  in  1  clears sticky flags (with clkEn)
- startOfFrame  in  1  frame sync pulse from the pilot detector
- estimatesDone  in  1  channel/timing estimates complete pulse
- sampleStrobe  in  1  buffer output strobe (one per output sample)
- bufferFull  in  1  alignment buffer full flag
- trellisStart  out  1  one-clkEn pulse; starts trellis and buffer read realignment
- lastSampleReset  out  1  one-clkEn pulse at end of frame or abort
- frameActive  out  1  high in START and RUN
- frameCount  out  16  completed-frame count, wraps
- sampleIndex  out  CNT_WIDTH  output sample index within the current frame
- stallErr  out  1  sticky: RUN timeout
- sofOverrun  out  1  sticky: SOF arrived while one was already pending
- overflowErr  out  1  sticky: bufferFull seen

Behaviour:
- Outputs are registered. All are 0 on reset. The state updates only on cycles where clkEn=1.
- Pending latches:
  - sofPend is set by startOfFrame; estPend is set by estimatesDone.
  - Both are cleared on the START transition.
  - An event arriving in the same cycle as the START transition re-sets its latch (set beats clear).
  - startOfFrame while sofPend=1 (and not being consumed that cycle) sets sofOverrun.
- States: IDLE, START, RUN, FLUSH.
- IDLE: when sofPend and estPend are both set (latched or arriving this cycle) -> START.
- START: trellisStart=1 for this one cycle. Load remaining=FRAME_OUTPUTS-1, sampleIndex=0, timeout=0. Next state RUN.
- RUN:
  - On each sampleStrobe: sampleIndex++, remaining--, timeout=0.
  - sampleStrobe with remaining==0: lastSampleReset pulses next cycle, frameCount++, go to FLUSH.
  - Without sampleStrobe, timeout increments. At timeout==TIMEOUT_CLKS-1: set stallErr, pulse lastSampleReset, go to IDLE. frameCount is unchanged.
- FLUSH: count FLUSH_CLKS enabled clocks, then go to IDLE. IDLE re-enters START immediately if both latches are set, so there is no gap beyond the single IDLE cycle.
- Latency:
  - startOfFrame and estimatesDone both pending -> trellisStart 2 enabled clocks later (IDLE->START registered).
  - Final strobe -> lastSampleReset 1 clock later.
- trellisStart and lastSampleReset are never high together.
- enable=0: next enabled clock goes to IDLE and clears the latches. If the block was in RUN it pulses lastSampleReset; frameActive drops.
- bufferFull=1 in any state sets overflowErr. Scheduling is unaffected.
- clearErrors and a new error in the same cycle: the error wins.
- frameCount wraps 0xFFFF->0.
- Asynchronous reset mid-frame: immediate return to IDLE with all outputs 0.

Decomposition:
- Shared stcDefines.vh holds:
  - state encodings;
  - default FRAME_OUTPUTS, derived from PILOT_SAMPLES_PER_FRAME and the decimation ratio;
  - default TIMEOUT_CLKS.
- One sub-module, stc_event_latch, instantiated twice: set/clear/overrun latch with set-priority.

Test Plan:
- SOF at t=10, estimatesDone at t=20 (clkEn=1) -> trellisStart at t=22. FRAME_OUTPUTS=16 strobes every 4 clocks -> lastSampleReset one clock after the 16th strobe. frameCount=1, sampleIndex reached 15.
- estimatesDone before SOF, both during FLUSH of the previous frame -> trellisStart exactly one cycle after FLUSH ends. No lost frame.
- Two SOFs with no estimatesDone between them -> sofOverrun=1. clearErrors -> 0. A simultaneous SOF+clearErrors leaves it 1.
- Strobes stop mid-frame with TIMEOUT_CLKS=32 -> stallErr=1 after 32 enabled clocks, lastSampleReset pulse, frameCount unchanged, state IDLE.
- clkEn toggled 1-in-3 -> identical event sequence as with clkEn=1, stretched by 3x. No pulse lasts more than one enabled cycle.
- enable dropped mid-RUN -> lastSampleReset pulse, frameActive=0, latches cleared. A later SOF alone produces no trellisStart. Async reset mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/stc_frame_scheduler_pkg.sv
// Shared definitions for the STC frame scheduler.
// Holds the FSM state encoding and the default frame geometry.
// Default output samples per frame = pilot-frame samples / decimation ratio.
package stc_frame_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam int PILOT_SAMPLES_PER_FRAME = 6400;
    localparam int DECIM_RATIO             = 2;
    localparam int DEF_FRAME_OUTPUTS       = PILOT_SAMPLES_PER_FRAME / DECIM_RATIO;
    localparam int DEF_FLUSH_CLKS          = 8;
    localparam int DEF_TIMEOUT_CLKS        = 1024;
    localparam int DEF_CNT_WIDTH           = 16;
    localparam int FRAME_CNT_W             = 16;

endpackage

// File: rtl/stc_frame_scheduler_if.sv
// Signal bundle between the frame scheduler and its surroundings.
// master: drives clkEn, enable, clearErrors and the event inputs;
//         observes the scheduler outputs.
// slave : the scheduler itself.
interface stc_frame_scheduler_if
    import stc_frame_scheduler_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
);
    logic                   clkEn;
    logic                   enable;
    logic                   clearErrors;
    logic                   startOfFrame;
    logic                   estimatesDone;
    logic                   sampleStrobe;
    logic                   bufferFull;
    logic                   trellisStart;
    logic                   lastSampleReset;
    logic                   frameActive;
    logic [FRAME_CNT_W-1:0] frameCount;
    logic [CNT_WIDTH-1:0]   sampleIndex;
    logic                   stallErr;
    logic                   sofOverrun;
    logic                   overflowErr;

    modport master (
        output clkEn, enable, clearErrors, startOfFrame, estimatesDone,
               sampleStrobe, bufferFull,
        input  trellisStart, lastSampleReset, frameActive, frameCount,
               sampleIndex, stallErr, sofOverrun, overflowErr
    );

    modport slave (
        input  clkEn, enable, clearErrors, startOfFrame, estimatesDone,
               sampleStrobe, bufferFull,
        output trellisStart, lastSampleReset, frameActive, frameCount,
               sampleIndex, stallErr, sofOverrun, overflowErr
    );
endinterface

// File: rtl/stc_frame_scheduler_event_latch.sv
// Set-priority pending-event latch.
// Ports: clk, reset (async, active-high), en_i (clock enable),
//        set_i (event), clr_i (consume), pend_o (latched event).
// A set arriving in the same enabled cycle as a clear keeps the latch set.
module stc_frame_scheduler_event_latch (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic set_i,
    input  logic clr_i,
    output logic pend_o
);
    logic pend_q;
    logic pend_d;

    always_comb begin
        pend_d = set_i | (pend_q & ~clr_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= 1'b0;
        end else if (en_i) begin
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;
endmodule

// File: rtl/stc_frame_scheduler.sv
// Per-frame controller for the STC frame-alignment buffer and trellis.
// Pairs start-of-frame with estimate completion, issues one trellisStart per
// frame, counts output samples, issues lastSampleReset at frame end/abort,
// and keeps sticky stall / SOF-overrun / overflow flags.
// Ports: clk, reset (async, active-high), bus (slave modport: clkEn, enable,
//        clearErrors, event inputs in; pulses, counters, sticky flags out).
module stc_frame_scheduler
    import stc_frame_scheduler_pkg::*;
#(
    parameter int FRAME_OUTPUTS = DEF_FRAME_OUTPUTS,
    parameter int FLUSH_CLKS    = DEF_FLUSH_CLKS,
    parameter int TIMEOUT_CLKS  = DEF_TIMEOUT_CLKS,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    stc_frame_scheduler_if.slave  bus
);
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   remaining_q, remaining_d;
    logic [CNT_WIDTH-1:0]   sampleIndex_q, sampleIndex_d;
    // Shared by the RUN stall timeout and the FLUSH hold count.
    logic [CNT_WIDTH-1:0]   timer_q, timer_d;
    logic [FRAME_CNT_W-1:0] frameCount_q, frameCount_d;
    logic trellisStart_q, trellisStart_d;
    logic lastSampleReset_q, lastSampleReset_d;
    logic frameActive_q, frameActive_d;
    logic stallErr_q, stallErr_d;
    logic sofOverrun_q, sofOverrun_d;
    logic overflowErr_q, overflowErr_d;

    logic sofSet, estSet, latchClr, sofPend, estPend;
    logic stallEvt, sofOverrunEvt;

    // Events are ignored while disabled; latches are consumed in START.
    assign sofSet   = bus.startOfFrame  & bus.enable;
    assign estSet   = bus.estimatesDone & bus.enable;
    assign latchClr = (state_q == ST_START) | ~bus.enable;
    assign sofOverrunEvt = sofSet & sofPend & ~latchClr;

    stc_frame_scheduler_event_latch u_sof_latch (
        .clk    (clk),
        .reset  (reset),
        .en_i   (bus.clkEn),
        .set_i  (sofSet),
        .clr_i  (latchClr),
        .pend_o (sofPend)
    );

    stc_frame_scheduler_event_latch u_est_latch (
        .clk    (clk),
        .reset  (reset),
        .en_i   (bus.clkEn),
        .set_i  (estSet),
        .clr_i  (latchClr),
        .pend_o (estPend)
    );

    always_comb begin
        state_d           = state_q;
        remaining_d       = remaining_q;
        sampleIndex_d     = sampleIndex_q;
        timer_d           = timer_q;
        frameCount_d      = frameCount_q;
        trellisStart_d    = 1'b0;
        lastSampleReset_d = 1'b0;
        stallEvt          = 1'b0;

        if (!bus.enable) begin
            state_d = ST_IDLE;
            if (state_q == ST_RUN) lastSampleReset_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Both events count whether latched or arriving now.
                    if ((sofPend | sofSet) && (estPend | estSet)) state_d = ST_START;
                end
                ST_START: begin
                    trellisStart_d = 1'b1;
                    remaining_d    = CNT_WIDTH'(FRAME_OUTPUTS - 1);
                    sampleIndex_d  = '0;
                    timer_d        = '0;
                    state_d        = ST_RUN;
                end
                ST_RUN: begin
                    if (bus.sampleStrobe) begin
                        timer_d = '0;
                        if (remaining_q == '0) begin
                            lastSampleReset_d = 1'b1;
                            frameCount_d      = frameCount_q + 1'b1;
                            state_d           = ST_FLUSH;
                        end else begin
                            sampleIndex_d = sampleIndex_q + 1'b1;
                            remaining_d   = remaining_q - 1'b1;
                        end
                    end else if (timer_q == CNT_WIDTH'(TIMEOUT_CLKS - 1)) begin
                        stallEvt          = 1'b1;
                        lastSampleReset_d = 1'b1;
                        state_d           = ST_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (timer_q == CNT_WIDTH'(FLUSH_CLKS - 1)) state_d = ST_IDLE;
                    else timer_d = timer_q + 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        frameActive_d = (state_d == ST_START) || (state_d == ST_RUN);

        // New error beats a simultaneous clear.
        stallErr_d    = stallEvt       | (stallErr_q    & ~bus.clearErrors);
        sofOverrun_d  = sofOverrunEvt  | (sofOverrun_q  & ~bus.clearErrors);
        overflowErr_d = bus.bufferFull | (overflowErr_q & ~bus.clearErrors);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            remaining_q       <= '0;
            sampleIndex_q     <= '0;
            timer_q           <= '0;
            frameCount_q      <= '0;
            trellisStart_q    <= 1'b0;
            lastSampleReset_q <= 1'b0;
            frameActive_q     <= 1'b0;
            stallErr_q        <= 1'b0;
            sofOverrun_q      <= 1'b0;
            overflowErr_q     <= 1'b0;
        end else if (bus.clkEn) begin
            state_q           <= state_d;
            remaining_q       <= remaining_d;
            sampleIndex_q     <= sampleIndex_d;
            timer_q           <= timer_d;
            frameCount_q      <= frameCount_d;
            trellisStart_q    <= trellisStart_d;
            lastSampleReset_q <= lastSampleReset_d;
            frameActive_q     <= frameActive_d;
            stallErr_q        <= stallErr_d;
            sofOverrun_q      <= sofOverrun_d;
            overflowErr_q     <= overflowErr_d;
        end
    end

    assign bus.trellisStart    = trellisStart_q;
    assign bus.lastSampleReset = lastSampleReset_q;
    assign bus.frameActive     = frameActive_q;
    assign bus.frameCount      = frameCount_q;
    assign bus.sampleIndex     = sampleIndex_q;
    assign bus.stallErr        = stallErr_q;
    assign bus.sofOverrun      = sofOverrun_q;
    assign bus.overflowErr     = overflowErr_q;
endmodule

// File: tb/tb_stc_frame_scheduler.sv
module tb_stc_frame_scheduler;
    import stc_frame_scheduler_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    stc_frame_scheduler_if #(.CNT_WIDTH(16)) bus ();

    stc_frame_scheduler #(
        .FRAME_OUTPUTS (16),
        .FLUSH_CLKS    (8),
        .TIMEOUT_CLKS  (32),
        .CNT_WIDTH     (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enabled clock out of every three raw clocks.
    task automatic etick();
        bus.clkEn = 1'b0;
        tick();
        tick();
        bus.clkEn = 1'b1;
        tick();
        bus.clkEn = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        reset             = 1'b1;
        bus.clkEn         = 1'b1;
        bus.enable        = 1'b1;
        bus.clearErrors   = 1'b0;
        bus.startOfFrame  = 1'b0;
        bus.estimatesDone = 1'b0;
        bus.sampleStrobe  = 1'b0;
        bus.bufferFull    = 1'b0;
        tick();
        tick();
        chk("rst_trellis", 32'(bus.trellisStart), 0);
        chk("rst_lsr", 32'(bus.lastSampleReset), 0);
        chk("rst_active", 32'(bus.frameActive), 0);
        chk("rst_fcount", 32'(bus.frameCount), 0);
        chk("rst_sidx", 32'(bus.sampleIndex), 0);
        chk("rst_errs", {29'd0, bus.stallErr, bus.sofOverrun, bus.overflowErr}, 0);
        reset = 1'b0;
        tick();

        // Frame 1: SOF, then estimates later, 16 strobes every 4 clocks.
        bus.startOfFrame = 1'b1; tick(); bus.startOfFrame = 1'b0;
        repeat (8) tick();
        chk("sof_only_no_start", 32'(bus.frameActive), 0);
        bus.estimatesDone = 1'b1; tick(); bus.estimatesDone = 1'b0;
        chk("f1_start_active", 32'(bus.frameActive), 1);
        chk("f1_trellis_early", 32'(bus.trellisStart), 0);
        tick();
        chk("f1_trellis", 32'(bus.trellisStart), 1);
        tick();
        chk("f1_trellis_one", 32'(bus.trellisStart), 0);
        for (int i = 0; i < 16; i++) begin
            repeat (3) tick();
            bus.sampleStrobe = 1'b1; tick(); bus.sampleStrobe = 1'b0;
            if (i < 15) begin
                chk("f1_sidx", 32'(bus.sampleIndex), 32'(i + 1));
                chk("f1_lsr_early", 32'(bus.lastSampleReset), 0);
            end
        end
        chk("f1_lsr", 32'(bus.lastSampleReset), 1);
        chk("f1_not_both", 32'(bus.trellisStart), 0);
        chk("f1_fcount", 32'(bus.frameCount), 1);
        chk("f1_sidx_last", 32'(bus.sampleIndex), 15);
        chk("f1_flush_inactive", 32'(bus.frameActive), 0);
        tick();
        chk("f1_lsr_one", 32'(bus.lastSampleReset), 0);

        // Frame 2 events arrive during FLUSH (estimates first).
        bus.estimatesDone = 1'b1; tick(); bus.estimatesDone = 1'b0;
        bus.startOfFrame  = 1'b1; tick(); bus.startOfFrame  = 1'b0;
        chk("flush_no_overrun", 32'(bus.sofOverrun), 0);
        repeat (5) tick();
        chk("flush_end_idle", 32'(bus.frameActive), 0);
        tick();
        chk("f2_start_active", 32'(bus.frameActive), 1);
        chk("f2_trellis_early", 32'(bus.trellisStart), 0);
        tick();
        chk("f2_trellis", 32'(bus.trellisStart), 1);

        // Frame 2 stalls: no strobes at all.
        repeat (31) tick();
        chk("stall_early", 32'(bus.stallErr), 0);
        chk("stall_lsr_early", 32'(bus.lastSampleReset), 0);
        tick();
        chk("stall_err", 32'(bus.stallErr), 1);
        chk("stall_lsr", 32'(bus.lastSampleReset), 1);
        chk("stall_fcount", 32'(bus.frameCount), 1);
        chk("stall_idle", 32'(bus.frameActive), 0);
        tick();
        chk("stall_lsr_one", 32'(bus.lastSampleReset), 0);
        chk("stall_sticky", 32'(bus.stallErr), 1);

        // SOF overrun and clearErrors priority.
        bus.startOfFrame = 1'b1; tick(); bus.startOfFrame = 1'b0;
        chk("ovr_first_sof", 32'(bus.sofOverrun), 0);
        tick();
        bus.startOfFrame = 1'b1; tick(); bus.startOfFrame = 1'b0;
        chk("ovr_second_sof", 32'(bus.sofOverrun), 1);
        bus.clearErrors = 1'b1; tick(); bus.clearErrors = 1'b0;
        chk("ovr_cleared", 32'(bus.sofOverrun), 0);
        chk("stall_cleared", 32'(bus.stallErr), 0);
        bus.startOfFrame = 1'b1; bus.clearErrors = 1'b1; tick();
        bus.startOfFrame = 1'b0; bus.clearErrors = 1'b0;
        chk("ovr_beats_clear", 32'(bus.sofOverrun), 1);

        // Buffer overflow flag.
        bus.bufferFull = 1'b1; tick(); bus.bufferFull = 1'b0;
        chk("ovf_set", 32'(bus.overflowErr), 1);
        chk("ovf_no_sched", 32'(bus.frameActive), 0);
        bus.bufferFull = 1'b1; bus.clearErrors = 1'b1; tick(); bus.bufferFull = 1'b0;
        chk("ovf_beats_clear", 32'(bus.overflowErr), 1);
        tick(); bus.clearErrors = 1'b0;
        chk("ovf_cleared", 32'(bus.overflowErr), 0);

        // Frame 3 aborted by enable drop (SOF still latched).
        bus.estimatesDone = 1'b1; tick(); bus.estimatesDone = 1'b0;
        chk("f3_active", 32'(bus.frameActive), 1);
        tick();
        chk("f3_trellis", 32'(bus.trellisStart), 1);
        bus.sampleStrobe = 1'b1; tick(); bus.sampleStrobe = 1'b0;
        chk("f3_sidx", 32'(bus.sampleIndex), 1);
        bus.enable = 1'b0; tick(); bus.enable = 1'b1;
        chk("dis_lsr", 32'(bus.lastSampleReset), 1);
        chk("dis_inactive", 32'(bus.frameActive), 0);
        chk("dis_fcount", 32'(bus.frameCount), 1);
        tick();
        chk("dis_lsr_one", 32'(bus.lastSampleReset), 0);
        bus.startOfFrame = 1'b1; tick(); bus.startOfFrame = 1'b0;
        repeat (5) begin
            tick();
            chk("dis_latch_cleared_trellis", 32'(bus.trellisStart), 0);
        end
        chk("dis_latch_cleared_active", 32'(bus.frameActive), 0);

        // Frame 4 interrupted by asynchronous reset mid-RUN.
        bus.estimatesDone = 1'b1; tick(); bus.estimatesDone = 1'b0;
        tick();
        chk("f4_trellis", 32'(bus.trellisStart), 1);
        bus.sampleStrobe = 1'b1; tick(); tick(); bus.sampleStrobe = 1'b0;
        bus.bufferFull = 1'b1; tick(); bus.bufferFull = 1'b0;
        chk("f4_active", 32'(bus.frameActive), 1);
        chk("f4_sidx", 32'(bus.sampleIndex), 2);
        #3 reset = 1'b1;
        #1;
        chk("arst_active", 32'(bus.frameActive), 0);
        chk("arst_sidx", 32'(bus.sampleIndex), 0);
        chk("arst_fcount", 32'(bus.frameCount), 0);
        chk("arst_ovf", 32'(bus.overflowErr), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("arst_idle", 32'(bus.frameActive), 0);

        // clkEn 1-in-3: same frame sequence, stretched.
        bus.clkEn = 1'b0;
        bus.startOfFrame  = 1'b1; etick(); bus.startOfFrame  = 1'b0;
        bus.estimatesDone = 1'b1; etick(); bus.estimatesDone = 1'b0;
        chk("ce_active", 32'(bus.frameActive), 1);
        chk("ce_trellis_early", 32'(bus.trellisStart), 0);
        etick();
        chk("ce_trellis", 32'(bus.trellisStart), 1);
        tick();
        chk("ce_trellis_held", 32'(bus.trellisStart), 1);
        tick();
        bus.clkEn = 1'b1; tick(); bus.clkEn = 1'b0;
        chk("ce_trellis_one", 32'(bus.trellisStart), 0);
        bus.sampleStrobe = 1'b1;
        for (int i = 0; i < 16; i++) begin
            etick();
            if (i < 15) chk("ce_sidx", 32'(bus.sampleIndex), 32'(i + 1));
        end
        bus.sampleStrobe = 1'b0;
        chk("ce_lsr", 32'(bus.lastSampleReset), 1);
        chk("ce_fcount", 32'(bus.frameCount), 1);
        chk("ce_sidx_last", 32'(bus.sampleIndex), 15);
        etick();
        chk("ce_lsr_one", 32'(bus.lastSampleReset), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
